// File: rtl/control_multi_pkg.sv
//------------------------------------------------------------------------------
// Package     : Parametros
// Description : Opcode, ALU-op, trap-cause and FSM state encodings shared by
//               the multicycle control unit. CSR_TRAP_EN adds the CSR/trap states.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package Parametros;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_URET = 32'h0020_0073;

  localparam logic [31:0] CAUSE_PC_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL       = 32'd2;
  localparam logic [31:0] CAUSE_LOAD_FAULT    = 32'd4;
  localparam logic [31:0] CAUSE_STORE_FAULT   = 32'd6;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9
  } alu_op_t;

  typedef enum logic [4:0] {
    ST_FETCH    = 5'd0,
    ST_DECODE   = 5'd1,
    ST_MEMADDR  = 5'd2,
    ST_MEMREAD  = 5'd3,
    ST_MEMWB    = 5'd4,
    ST_MEMWRITE = 5'd5,
    ST_EXEC_R   = 5'd6,
    ST_EXEC_I   = 5'd7,
    ST_LUI      = 5'd8,
    ST_ALUWB    = 5'd9,
    ST_BRANCH   = 5'd10,
    ST_JAL      = 5'd11,
    ST_JALR     = 5'd12
`ifdef CSR_TRAP_EN
    ,
    ST_CSR_RD   = 5'd13,
    ST_CSR_WR   = 5'd14,
    ST_TRAP     = 5'd15,
    ST_TRAP_JMP = 5'd16,
    ST_URET     = 5'd17,
    ST_URET_JMP = 5'd18
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/control_multi_alu_decode.sv
//------------------------------------------------------------------------------
// Module      : alu_decode
// Description : Combinational funct3/funct7[5] to ALU opcode decode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_decode
  import Parametros::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_op_i,
  output alu_op_t    alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (funct3_i)
      // OP-IMM has no SUBI: bit 30 there is immediate data
      3'b000:  alu_op_o = (is_op_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_o = ALU_SLL;
      3'b010:  alu_op_o = ALU_SLT;
      3'b011:  alu_op_o = ALU_SLTU;
      3'b100:  alu_op_o = ALU_XOR;
      3'b101:  alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_o = ALU_OR;
      default: alu_op_o = ALU_AND;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_multi.sv
//------------------------------------------------------------------------------
// Module      : control_multi
// Description : Moore-FSM control unit for a multicycle RV32I datapath.
//               Define CSR_TRAP_EN to add CSR access, traps and URET.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_multi
  import Parametros::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInstr,
`ifdef CSR_TRAP_EN
  input  logic        iPCMisaligned,
  input  logic        iExceptionLoad,
  input  logic        iExceptionStore,
  output logic [31:0] oUcause,
  output logic        oCSRWrite,
  output logic        oEscreveCSROut,
  output logic [2:0]  oOrigWriteDataCSR,
  output logic [1:0]  oSelectNumRegCSR,
`endif
  output logic        oEscreveIR,
  output logic        oEscrevePC,
  output logic        oEscrevePCCond,
  output logic        oEscrevePCBack,
  output logic        oIouD,
  output logic        oRegWrite,
  output logic        oMemWrite,
  output logic        oMemRead,
  output logic [1:0]  oOrigAULA,
  output logic [1:0]  oOrigBULA,
  output logic [2:0]  oMem2Reg,
  output logic [1:0]  oOrigPC,
  output logic [4:0]  oALUControl,
  output logic [4:0]  oState
);

  state_t     state_q, state_d;
  alu_op_t    decoded_op;
  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign oState = state_q;

  alu_decode u_alu_decode (
    .funct3_i   (funct3),
    .funct7b5_i (iInstr[30]),
    .is_op_i    (opcode == OPC_OP),
    .alu_op_o   (decoded_op)
  );

`ifdef CSR_TRAP_EN
  logic [31:0] ucause_q, ucause_d;
  assign oUcause = ucause_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) ucause_q <= '0;
    else      ucause_q <= ucause_d;
  end
`else
  logic unused_instr_bits;
  assign unused_instr_bits = ^{iInstr[31], iInstr[29:15], iInstr[11:7]};
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= ST_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = ST_FETCH;
    oEscreveIR     = 1'b0;
    oEscrevePC     = 1'b0;
    oEscrevePCCond = 1'b0;
    oEscrevePCBack = 1'b0;
    oIouD          = 1'b0;
    oRegWrite      = 1'b0;
    oMemWrite      = 1'b0;
    oMemRead       = 1'b0;
    oOrigAULA      = 2'b00;
    oOrigBULA      = 2'b00;
    oMem2Reg       = 3'b000;
    oOrigPC        = 2'b00;
    oALUControl    = ALU_ADD;
`ifdef CSR_TRAP_EN
    ucause_d          = ucause_q;
    oCSRWrite         = 1'b0;
    oEscreveCSROut    = 1'b0;
    oOrigWriteDataCSR = 3'b000;
    oSelectNumRegCSR  = 2'b00;
`endif

    case (state_q)
      ST_FETCH: begin
        oMemRead       = 1'b1;
        oEscrevePCBack = 1'b1;
        oOrigAULA      = 2'b01;
        oOrigBULA      = 2'b01;
        oEscreveIR     = 1'b1;
        oEscrevePC     = 1'b1;
        state_d        = ST_DECODE;
`ifdef CSR_TRAP_EN
        if (iPCMisaligned) begin
          oEscreveIR = 1'b0;
          oEscrevePC = 1'b0;
          ucause_d   = CAUSE_PC_MISALIGNED;
          state_d    = ST_TRAP;
        end
`endif
      end

      ST_DECODE: begin
        // Precompute PCBack + imm so branch/AUIPC targets sit in ALUOut
        oOrigAULA = 2'b10;
        oOrigBULA = 2'b10;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = ST_MEMADDR;
          OPC_OP:              state_d = ST_EXEC_R;
          OPC_OPIMM:           state_d = ST_EXEC_I;
          OPC_BRANCH:          state_d = ST_BRANCH;
          OPC_JAL:             state_d = ST_JAL;
          OPC_JALR:            state_d = ST_JALR;
          OPC_LUI:             state_d = ST_LUI;
          OPC_AUIPC:           state_d = ST_ALUWB;
`ifdef CSR_TRAP_EN
          OPC_SYSTEM: begin
            if (funct3 != 3'b000) begin
              state_d = ST_CSR_RD;
            end else if (iInstr == INSTR_URET) begin
              state_d = ST_URET;
            end else begin
              ucause_d = CAUSE_ILLEGAL;
              state_d  = ST_TRAP;
            end
          end
          default: begin
            ucause_d = CAUSE_ILLEGAL;
            state_d  = ST_TRAP;
          end
`else
          default:             state_d = ST_FETCH;
`endif
        endcase
      end

      ST_MEMADDR: begin
        oOrigBULA = 2'b10;
        // Bit 5 separates STORE (0100011) from LOAD (0000011)
        state_d   = iInstr[5] ? ST_MEMWRITE : ST_MEMREAD;
      end

      ST_MEMREAD: begin
        oMemRead = 1'b1;
        oIouD    = 1'b1;
        state_d  = ST_MEMWB;
`ifdef CSR_TRAP_EN
        if (iExceptionLoad) begin
          ucause_d = CAUSE_LOAD_FAULT;
          state_d  = ST_TRAP;
        end
`endif
      end

      ST_MEMWB: begin
        oMem2Reg  = 3'b010;
        oRegWrite = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_MEMWRITE: begin
        oMemWrite = 1'b1;
        oIouD     = 1'b1;
        state_d   = ST_FETCH;
`ifdef CSR_TRAP_EN
        if (iExceptionStore) begin
          oMemWrite = 1'b0;
          ucause_d  = CAUSE_STORE_FAULT;
          state_d   = ST_TRAP;
        end
`endif
      end

      ST_EXEC_R: begin
        oALUControl = decoded_op;
        state_d     = ST_ALUWB;
      end

      ST_EXEC_I: begin
        oOrigBULA   = 2'b10;
        oALUControl = decoded_op;
        state_d     = ST_ALUWB;
      end

      ST_LUI: begin
        oOrigAULA = 2'b11;
        oOrigBULA = 2'b10;
        state_d   = ST_ALUWB;
      end

      ST_ALUWB: begin
        oRegWrite = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_BRANCH: begin
        oEscrevePCCond = 1'b1;
        oOrigPC        = 2'b01;
        state_d        = ST_FETCH;
      end

      ST_JAL: begin
        oMem2Reg   = 3'b001;
        oRegWrite  = 1'b1;
        oEscrevePC = 1'b1;
        oOrigPC    = 2'b01;
        state_d    = ST_FETCH;
      end

      ST_JALR: begin
        // rs1 was latched into A earlier, so rd==rs1 writeback is safe here
        oOrigBULA  = 2'b10;
        oOrigPC    = 2'b10;
        oEscrevePC = 1'b1;
        oMem2Reg   = 3'b001;
        oRegWrite  = 1'b1;
        state_d    = ST_FETCH;
      end

`ifdef CSR_TRAP_EN
      ST_CSR_RD: begin
        oEscreveCSROut = 1'b1;
        state_d        = ST_CSR_WR;
      end

      ST_CSR_WR: begin
        oCSRWrite = 1'b1;
        oMem2Reg  = 3'b100;
        oRegWrite = 1'b1;
        case (funct3)
          3'b001:  oOrigWriteDataCSR = 3'b001;
          3'b010:  oOrigWriteDataCSR = 3'b010;
          3'b011:  oOrigWriteDataCSR = 3'b011;
          3'b110:  oOrigWriteDataCSR = 3'b100;
          3'b111:  oOrigWriteDataCSR = 3'b101;
          default: oOrigWriteDataCSR = 3'b000;
        endcase
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        oCSRWrite        = 1'b1;
        oSelectNumRegCSR = 2'b01;
        oEscreveCSROut   = 1'b1;
        state_d          = ST_TRAP_JMP;
      end

      ST_URET: begin
        oSelectNumRegCSR = 2'b10;
        oEscreveCSROut   = 1'b1;
        state_d          = ST_URET_JMP;
      end

      ST_TRAP_JMP, ST_URET_JMP: begin
        oOrigPC    = 2'b11;
        oEscrevePC = 1'b1;
        state_d    = ST_FETCH;
      end
`endif

      default: state_d = ST_FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/control_multi.md
CONTROL_MULTI -- requirements
Module: control_multi

Interface
REQ-001 SHALL have ports: iCLK in 1 clock; iRST in 1 reset, asynchronous, active-high.
REQ-002 SHALL have port iInstr in 32: the instruction register contents from the datapath.
REQ-003 SHALL have datapath strobe outputs, each 1 bit: oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack, oIouD, oRegWrite, oMemWrite, oMemRead.
REQ-004 SHALL have mux-select outputs: oOrigAULA out 2 (00 A, 01 PC, 10 PCBack, 11 zero); oOrigBULA out 2 (00 B, 01 4, 10 imm); oMem2Reg out 3 (000 ALUOut, 001 PC, 010 MDR, 100 CSROut); oOrigPC out 2 (00 ALU, 01 ALUOut, 10 ALU&~1, 11 CSROut).
REQ-005 SHALL have oALUControl out 5 (ALU opcode) and oState out 5 (current state, for monitoring).
REQ-006 SHALL add these ports only under CSR_TRAP_EN: iPCMisaligned, iExceptionLoad and iExceptionStore in 1; oUcause out 32; oCSRWrite and oEscreveCSROut out 1; oOrigWriteDataCSR out 3; oSelectNumRegCSR out 2.

Function
REQ-007 SHALL be a Moore FSM: all outputs decode from state plus iInstr; unlisted strobes 0, unlisted selects 0, oALUControl=ADD.
REQ-008 FETCH SHALL drive MemRead, IouD=0, EscreveIR, EscrevePCBack, OrigA=01, OrigB=01, ADD, OrigPC=00, EscrevePC; next DECODE.
REQ-009 DECODE SHALL drive OrigA=10, OrigB=10, ADD (ALUOut=branch/AUIPC target) and dispatch on iInstr[6:0].
REQ-010 Dispatch targets: load/store->MEMADDR; OP->EXEC_R; OP-IMM->EXEC_I; BRANCH->BRANCH; JAL->JAL; JALR->JALR; LUI->LUI; AUIPC->ALUWB.
REQ-011 MEMADDR SHALL drive OrigA=00, OrigB=10, ADD; next MEMREAD for loads, MEMWRITE for stores.
REQ-012 MEMREAD SHALL drive MemRead, IouD=1, then MEMWB; MEMWB SHALL drive Mem2Reg=010, RegWrite, then FETCH.
REQ-013 MEMWRITE SHALL drive MemWrite, IouD=1, then FETCH.
REQ-014 EXEC_R SHALL drive OrigA=00, OrigB=00; EXEC_I SHALL drive OrigA=00, OrigB=10; LUI SHALL drive OrigA=11, OrigB=10, ADD; all three then ALUWB.
REQ-015 ALUWB SHALL drive Mem2Reg=000, RegWrite, then FETCH.
REQ-016 ALU op from funct3/funct7[5]: 000 ADD (SUB only for OP with f7[5]=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRA if f7[5] else SRL, 110 OR, 111 AND.
REQ-017 BRANCH SHALL drive EscrevePCCond, OrigPC=01, then FETCH.
REQ-018 JAL SHALL drive Mem2Reg=001, RegWrite, EscrevePC, OrigPC=01, then FETCH.
REQ-019 JALR SHALL drive OrigA=00, OrigB=10, ADD, OrigPC=10, EscrevePC, Mem2Reg=001, RegWrite, then FETCH; rd==rs1 SHALL be correct because A is already latched.
REQ-020 Cycle counts: ALU/LUI/AUIPC 4 (AUIPC 3); load 5; store 4; branch, JAL, JALR 3.
REQ-021 Unknown opcode without CSR_TRAP_EN SHALL return to FETCH with no write strobe asserted.

Reset
REQ-022 iRST SHALL force state FETCH asynchronously; while iRST is high, outputs SHALL be the FETCH decode.
REQ-023 Reset mid-instruction SHALL abandon it; no state is retained.

Configuration
REQ-024 Macro CSR_TRAP_EN SHALL add states CSR_RD, CSR_WR, TRAP, TRAP_JMP, URET, URET_JMP.
REQ-025 With CSR_TRAP_EN, SYSTEM opcode: funct3!=0 ->CSR_RD; URET encoding ->URET; other/illegal opcodes ->TRAP cause 2.
REQ-026 CSR_RD SHALL drive SelectNumRegCSR=00, EscreveCSROut, then CSR_WR.
REQ-027 CSR_WR SHALL drive CSRWrite, Mem2Reg=100, RegWrite, OrigWriteDataCSR per funct3 (001->001, 010->010, 011->011, 101->000, 110->100, 111->101), then FETCH.
REQ-028 Exceptions: iPCMisaligned in FETCH->cause 0; iExceptionLoad in MEMREAD->cause 4; iExceptionStore in MEMWRITE->cause 6. The faulting state's EscreveIR/EscrevePC/MemWrite/RegWrite SHALL be suppressed; next TRAP.
REQ-029 TRAP SHALL drive CSRWrite, oUcause, SelectNumRegCSR=01, EscreveCSROut, then TRAP_JMP. URET SHALL drive SelectNumRegCSR=10, EscreveCSROut, then URET_JMP.
REQ-030 TRAP_JMP and URET_JMP SHALL drive OrigPC=11, EscrevePC, then FETCH.
REQ-031 oUcause SHALL be registered, holding 0 at reset and the last cause otherwise.
REQ-032 Without CSR_TRAP_EN, these states and ports SHALL be absent and REQ-021 SHALL apply.

Structure
REQ-033 Opcode, ALU-op and state encodings SHALL live in the shared Parametros package.
REQ-034 SHALL contain one combinational sub-module alu_decode (funct3, funct7[5], isOP -> ALU op).

Verification
REQ-035 0x00500093 (addi x1,x0,5): states FETCH,DECODE,EXEC_I,ALUWB; RegWrite only in ALUWB; ALU=ADD.
REQ-036 0x40208133 (sub): EXEC_R drives SUB; 0x4020d133 (sra) drives SRA.
REQ-037 0x0000a083 (lw): 5 cycles; MemRead with IouD=1 in MEMREAD; Mem2Reg=010 in MEMWB.
REQ-038 0x00000463 (beq): 3 cycles; EscrevePCCond=1, OrigPC=01 in BRANCH; no RegWrite.
REQ-039 0x00000000: without macro, FETCH after DECODE with no writes; with macro, TRAP, oUcause=2, then TRAP_JMP with OrigPC=11.
REQ-040 iRST pulsed in MEMREAD: oState=FETCH immediately; MemRead still asserted with IouD=0.
